// File: rtl/funct_generator_pkg.sv
// Shared types and constants for the function generator amplitude path.
// The amplitude register and its write-side controller both import this package.
package funct_generator_pkg;

    typedef enum logic [1:0] {
        AMP_CLR = 2'b00,
        AMP_INC = 2'b01,
        AMP_DEC = 2'b10,
        AMP_SET = 2'b11
    } amp_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } amp_state_e;

    // Must stay equal to the amplitude register's own reset value.
    localparam logic [7:0] AMP_RESET_VALUE = 8'h10;

    // Width of a counter that runs 0..div-1; never narrower than one bit.
    function automatic int prescaler_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/funct_generator_amp_ctrl_if.sv
// Amplitude command channel: valid/ready handshake carrying an operation and
// a target value (the target is only meaningful for SET).
interface funct_generator_amp_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    import funct_generator_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    amp_op_e               cmd_op;
    logic [DATA_WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/funct_generator_amp_clamp.sv
// Combinational next-amplitude calculator: INC/DEC/SET with clamping, or one
// ramp step toward an already-clamped target. Arithmetic is one bit wider so
// neither direction can wrap.
module funct_generator_amp_clamp
    import funct_generator_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] AMP_MIN    = '0,
    parameter logic [DATA_WIDTH-1:0] AMP_MAX    = '1,
    parameter int                    STEP       = 1
) (
    input  amp_op_e               op,
    input  logic                  ramp,
    input  logic [DATA_WIDTH-1:0] cur,
    input  logic [DATA_WIDTH-1:0] target,
    output logic [DATA_WIDTH-1:0] next,
    output logic                  sat
);

    localparam int            XW     = DATA_WIDTH + 1;
    localparam logic [XW-1:0] MIN_X  = {1'b0, AMP_MIN};
    localparam logic [XW-1:0] MAX_X  = {1'b0, AMP_MAX};
    localparam logic [XW-1:0] STEP_X = XW'(STEP);

    logic [XW-1:0] cur_x;
    logic [XW-1:0] tgt_x;
    logic [XW-1:0] sum_x;
    logic [XW-1:0] diff_x;
    logic [XW-1:0] dist_x;

    assign cur_x  = {1'b0, cur};
    assign tgt_x  = {1'b0, target};
    assign sum_x  = cur_x + STEP_X;
    assign diff_x = cur_x - STEP_X;
    assign dist_x = (tgt_x >= cur_x) ? (tgt_x - cur_x) : (cur_x - tgt_x);

    always_comb begin
        next = cur;
        sat  = 1'b0;
        if (ramp) begin
            // Final step is shortened so the ramp lands exactly on target.
            if (dist_x <= STEP_X) begin
                next = target;
            end else if (tgt_x > cur_x) begin
                next = sum_x[DATA_WIDTH-1:0];
            end else begin
                next = diff_x[DATA_WIDTH-1:0];
            end
        end else begin
            case (op)
                AMP_INC: begin
                    if (sum_x > MAX_X) begin
                        next = AMP_MAX;
                        sat  = 1'b1;
                    end else begin
                        next = sum_x[DATA_WIDTH-1:0];
                    end
                end
                AMP_DEC: begin
                    // MSB set means the subtraction went below zero.
                    if (diff_x[XW-1] || (diff_x < MIN_X)) begin
                        next = AMP_MIN;
                        sat  = 1'b1;
                    end else begin
                        next = diff_x[DATA_WIDTH-1:0];
                    end
                end
                AMP_SET: begin
                    if (tgt_x < MIN_X) begin
                        next = AMP_MIN;
                        sat  = 1'b1;
                    end else if (tgt_x > MAX_X) begin
                        next = AMP_MAX;
                        sat  = 1'b1;
                    end else begin
                        next = target;
                    end
                end
                default: begin
                    next = cur;
                end
            endcase
        end
    end

endmodule

// File: rtl/funct_generator_amp_ctrl.sv
// Write-side controller for the 8-bit amplitude holding register: turns
// commands into single-cycle clrh/enh pulses and glides SET targets in steps.
module funct_generator_amp_ctrl
    import funct_generator_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(AMP_RESET_VALUE),
    parameter logic [DATA_WIDTH-1:0] AMP_MIN     = '0,
    parameter logic [DATA_WIDTH-1:0] AMP_MAX     = '1,
    parameter int                    STEP        = 1,
    parameter int                    RAMP_DIV    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    funct_generator_amp_ctrl_if.slave        cmd,
    input  logic                             ramp_abort,
    output logic                             amp_clrh,
    output logic                             amp_enh,
    output logic [DATA_WIDTH-1:0]            amp_d,
    output logic [DATA_WIDTH-1:0]            cur_amp,
    output logic                             busy,
    output logic                             sat
);

    localparam int            PW             = prescaler_width(RAMP_DIV);
    localparam logic [PW-1:0] PRESCALE_LAST  = PW'(RAMP_DIV - 1);
    localparam logic [PW-1:0] PRESCALE_INC   = PW'(1);

    amp_state_e            state_reg;
    logic [PW-1:0]         prescaler_reg;
    logic [DATA_WIDTH-1:0] target_reg;

    logic                  ramp_sel;
    logic [DATA_WIDTH-1:0] clamp_target;
    logic [DATA_WIDTH-1:0] clamp_next;
    logic                  clamp_sat;

    assign cmd.cmd_ready = (state_reg == ST_IDLE);
    assign ramp_sel      = (state_reg == ST_RAMP);
    // While ramping the calculator steps toward the latched target instead of
    // evaluating whatever sits on the command bus.
    assign clamp_target  = ramp_sel ? target_reg : cmd.cmd_data;

    funct_generator_amp_clamp #(
        .DATA_WIDTH (DATA_WIDTH),
        .AMP_MIN    (AMP_MIN),
        .AMP_MAX    (AMP_MAX),
        .STEP       (STEP)
    ) u_clamp (
        .op     (cmd.cmd_op),
        .ramp   (ramp_sel),
        .cur    (cur_amp),
        .target (clamp_target),
        .next   (clamp_next),
        .sat    (clamp_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            prescaler_reg <= '0;
            target_reg    <= RESET_VALUE;
            cur_amp       <= RESET_VALUE;
            amp_d         <= RESET_VALUE;
            amp_enh       <= 1'b0;
            amp_clrh      <= 1'b0;
            busy          <= 1'b0;
            sat           <= 1'b0;
        end else begin
            amp_enh  <= 1'b0;
            amp_clrh <= 1'b0;
            sat      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        case (cmd.cmd_op)
                            AMP_CLR: begin
                                amp_clrh <= 1'b1;
                                cur_amp  <= RESET_VALUE;
                                amp_d    <= RESET_VALUE;
                            end
                            AMP_INC, AMP_DEC: begin
                                amp_enh <= 1'b1;
                                cur_amp <= clamp_next;
                                amp_d   <= clamp_next;
                                sat     <= clamp_sat;
                            end
                            AMP_SET: begin
                                sat <= clamp_sat;
                                if (clamp_next != cur_amp) begin
                                    state_reg     <= ST_RAMP;
                                    busy          <= 1'b1;
                                    prescaler_reg <= '0;
                                    target_reg    <= clamp_next;
                                end
                            end
                            default: begin
                                state_reg <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_RAMP: begin
                    // Abort takes priority over a coinciding step.
                    if (ramp_abort) begin
                        state_reg     <= ST_IDLE;
                        busy          <= 1'b0;
                        prescaler_reg <= '0;
                    end else if (prescaler_reg == PRESCALE_LAST) begin
                        prescaler_reg <= '0;
                        amp_enh       <= 1'b1;
                        cur_amp       <= clamp_next;
                        amp_d         <= clamp_next;
                        if (clamp_next == target_reg) begin
                            state_reg <= ST_IDLE;
                            busy      <= 1'b0;
                        end
                    end else begin
                        prescaler_reg <= prescaler_reg + PRESCALE_INC;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_funct_generator_amp_ctrl.sv
// Scoreboard bench: the driver predicts every clrh/enh/sat pulse from a plain
// integer model of the amplitude rules; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_funct_generator_amp_ctrl;
    import funct_generator_pkg::*;

    localparam int W    = 8;
    localparam int STEP = 3;
    localparam int DIV  = 4;
    localparam int AMIN = 2;
    localparam int AMAX = 240;
    localparam int RV   = 16;

    typedef struct {
        bit clrh;
        bit enh;
        bit sat;
        int d;
        int cyc;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ramp_abort = 1'b0;
    logic         amp_clrh, amp_enh, busy, sat;
    logic [W-1:0] amp_d, cur_amp;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  model_amp = RV;
    ev_t exp_q[$];
    ev_t mon_e;
    amp_op_e rop;
    int  rdata;
    bit  rabort;
    int  rd;

    funct_generator_amp_ctrl_if #(.DATA_WIDTH(W)) cmd_bus ();

    funct_generator_amp_ctrl #(
        .DATA_WIDTH  (W),
        .RESET_VALUE (8'h10),
        .AMP_MIN     (8'h02),
        .AMP_MAX     (8'hF0),
        .STEP        (STEP),
        .RAMP_DIV    (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_bus),
        .ramp_abort (ramp_abort),
        .amp_clrh   (amp_clrh),
        .amp_enh    (amp_enh),
        .amp_d      (amp_d),
        .cur_amp    (cur_amp),
        .busy       (busy),
        .sat        (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    function automatic int clampv(input int v);
        return (v < AMIN) ? AMIN : ((v > AMAX) ? AMAX : v);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic push(input bit c, input bit e, input bit s, input int d, input int at);
        ev_t ev;
        ev.clrh = c;
        ev.enh  = e;
        ev.sat  = s;
        ev.d    = d;
        ev.cyc  = at;
        exp_q.push_back(ev);
    endtask

    // Monitor: every pulse the DUT shows must be the next predicted one.
    always @(negedge clk) begin
        if (!rst && (amp_enh || amp_clrh || sat)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: clrh=%b enh=%b sat=%b d=%0h at cycle %0d, required no pulse",
                         amp_clrh, amp_enh, sat, amp_d, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_flags", 32'({amp_clrh, amp_enh, sat}), 32'({mon_e.clrh, mon_e.enh, mon_e.sat}));
                check("pulse_amp_d", 32'(amp_d), 32'(mon_e.d));
                check("pulse_cur_amp", 32'(cur_amp), 32'(mon_e.d));
                check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_bus.cmd_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_bus.cmd_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: cmd_ready=0 after %0d cycles, required 1", k);
        end
    endtask

    // Issue one command, predict its pulses, and follow any ramp to its end.
    task automatic run_cmd(input amp_op_e op, input int data, input bit do_abort, input int abort_d);
        int acc, t, a, n, stop;
        int steps[$];
        wait_ready();
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_data  = W'(data);
        cmd_bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_bus.cmd_valid = 1'b0;
        case (op)
            AMP_CLR: begin
                model_amp = RV;
                push(1'b1, 1'b0, 1'b0, RV, acc);
            end
            AMP_INC, AMP_DEC: begin
                a = (op == AMP_INC) ? model_amp + STEP : model_amp - STEP;
                t = clampv(a);
                model_amp = t;
                push(1'b0, 1'b1, (t != a), t, acc);
            end
            default: begin
                t = clampv(data);
                if (t != data) push(1'b0, 1'b0, 1'b1, model_amp, acc);
                a = model_amp;
                while (a != t) begin
                    a = (t > a) ? a + imin(STEP, t - a) : a - imin(STEP, a - t);
                    steps.push_back(a);
                end
                n = steps.size();
                stop = n;
                if (do_abort && (abort_d / DIV) < n) stop = abort_d / DIV;
                for (int j = 0; j < stop; j++) push(1'b0, 1'b1, 1'b0, steps[j], acc + (j + 1) * DIV);
                if (stop > 0) model_amp = steps[stop - 1];
                if (n == 0) begin
                    check("set_no_ramp_ready", 32'({busy, cmd_bus.cmd_ready}), 32'(2'b01));
                end else begin
                    check("ramp_entry", 32'({busy, cmd_bus.cmd_ready}), 32'(2'b10));
                    if (stop < n) begin
                        repeat (abort_d) @(posedge clk);
                        #1 ramp_abort = 1'b1;
                        @(posedge clk);
                        #1 ramp_abort = 1'b0;
                        check("abort_exit", 32'({busy, cmd_bus.cmd_ready}), 32'(2'b01));
                    end else begin
                        repeat (n * DIV - 1) @(posedge clk);
                        #1;
                        check("ramp_busy_hold", 32'(busy), 32'(1));
                        @(posedge clk);
                        #1;
                        check("ramp_exit", 32'({busy, cmd_bus.cmd_ready}), 32'(2'b01));
                        if (do_abort) begin
                            // Abort arriving in IDLE must be ignored.
                            ramp_abort = 1'b1;
                            @(posedge clk);
                            #1 ramp_abort = 1'b0;
                        end
                    end
                end
            end
        endcase
        check("cur_amp", 32'(cur_amp), 32'(model_amp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = AMP_CLR;
        cmd_bus.cmd_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_outputs", 32'({amp_clrh, amp_enh, busy, sat, cmd_bus.cmd_ready}), 32'(5'b00001));
        check("reset_cur_amp", 32'(cur_amp), 32'(RV));
        check("reset_amp_d", 32'(amp_d), 32'(RV));

        run_cmd(AMP_INC, 0, 1'b0, 0);
        run_cmd(AMP_INC, 0, 1'b0, 0);
        run_cmd(AMP_CLR, 0, 1'b0, 0);
        run_cmd(AMP_SET, 8'h20, 1'b0, 0);
        run_cmd(AMP_SET, 8'hFF, 1'b0, 0);
        run_cmd(AMP_INC, 0, 1'b0, 0);
        run_cmd(AMP_INC, 0, 1'b0, 0);
        run_cmd(AMP_SET, 8'h05, 1'b0, 0);
        run_cmd(AMP_DEC, 0, 1'b0, 0);
        run_cmd(AMP_DEC, 0, 1'b0, 0);
        run_cmd(AMP_SET, 8'h00, 1'b0, 0);
        run_cmd(AMP_SET, 8'h40, 1'b1, 2 * DIV);
        run_cmd(AMP_SET, 8'h09, 1'b1, DIV - 1);

        // Reset in the middle of a ramp, right after the second step edge.
        wait_ready();
        cmd_bus.cmd_op    = AMP_SET;
        cmd_bus.cmd_data  = 8'h80;
        cmd_bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_bus.cmd_valid = 1'b0;
        push(1'b0, 1'b1, 1'b0, model_amp + STEP, cyc + DIV);
        repeat (2 * DIV - 1) @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midramp_reset_flags", 32'({amp_clrh, amp_enh, busy, sat, cmd_bus.cmd_ready}), 32'(5'b00001));
        check("midramp_reset_amp", 32'({cur_amp, amp_d}), 32'({8'(RV), 8'(RV)}));
        check("midramp_queue_empty", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_amp = RV;

        for (int i = 0; i < 120; i++) begin
            rop    = amp_op_e'($urandom_range(3, 0));
            rdata  = int'($urandom_range(255, 0));
            rabort = ($urandom_range(3, 0) == 0);
            rd     = int'($urandom_range(60, 0));
            run_cmd(rop, rdata, rabort, rd);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/funct_generator_amp_ctrl.md
Name: funct_generator_amp_ctrl

Overview:
- Write-side controller for the function generator's 8-bit amplitude holding register.
- Accepts amplitude commands (clear, increment, decrement, set-with-ramp) over a valid/ready handshake.
- Drives the register's clrh/enh/d inputs with single-cycle pulses and keeps a shadow copy of the programmed amplitude.
- A SET command glides the amplitude toward the target in STEP increments, one step every RAMP_DIV clocks, so the output waveform never jumps.

Parameters:
- DATA_WIDTH, 8: amplitude width.
- RESET_VALUE, 8'h10: amplitude after reset or clear; must match the register's reset value.
- AMP_MIN, 8'h00: lower clamp.
- AMP_MAX, 8'hFF: upper clamp.
- STEP, 1: increment/decrement and ramp step size, in range 1..AMP_MAX.
- RAMP_DIV, 16: clocks per ramp step, minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_op  in  2  00 CLR, 01 INC, 10 DEC, 11 SET.
- cmd_data  in  DATA_WIDTH  target amplitude; used by SET only.
- ramp_abort  in  1  stops an active ramp.
- amp_clrh  out  1  clear pulse to the amplitude register.
- amp_enh  out  1  load-enable pulse to the amplitude register.
- amp_d  out  DATA_WIDTH  load data to the amplitude register.
- cur_amp  out  DATA_WIDTH  shadow of the programmed amplitude.
- busy  out  1  high while in RAMP.
- sat  out  1  one-cycle pulse when a result was clamped.

Behaviour:
Reset (rst is asynchronous, active-high; clock is clk):
- state=IDLE, prescaler=0, cur_amp=RESET_VALUE, amp_d=RESET_VALUE.
- amp_enh=0, amp_clrh=0, busy=0, sat=0.

Output timing:
- All outputs except cmd_ready are registered.
- cmd_ready = (state==IDLE), combinational from state.
- A command accepted at edge N drives amp_enh/amp_clrh high for exactly the cycle after N; the register captures at edge N+1.
- cur_amp updates at edge N, so it equals the value on amp_d.
- amp_enh and amp_clrh are never high together and never high for two consecutive cycles from the same command.

Arithmetic and clamping:
- Computed at DATA_WIDTH+1 bits so no wrap-around is possible.
- INC: cur_amp+STEP, clamped to AMP_MAX.
- DEC: cur_amp-STEP, clamped to AMP_MIN; underflow detected via the extra bit.
- sat pulses in the same cycle as amp_enh whenever the clamp changed the value.
- INC at AMP_MAX and DEC at AMP_MIN still issue amp_enh with an unchanged amp_d and pulse sat.

IDLE state:
- CLR: amp_clrh pulse, cur_amp and amp_d set to RESET_VALUE. Remain in IDLE.
- INC/DEC: amp_enh pulse with the computed value. Remain in IDLE.
- SET: target is cmd_data clamped to [AMP_MIN, AMP_MAX]; sat pulses at accept if clamped.
  - If target==cur_amp: no write, remain in IDLE.
  - Otherwise: go to RAMP, busy=1, prescaler=0.

RAMP state:
- cmd_ready=0.
- prescaler counts 0..RAMP_DIV-1.
- On the cycle prescaler==RAMP_DIV-1: cur_amp moves toward target by min(STEP, |target-cur_amp|), amp_enh pulses with the new value, prescaler wraps to 0.
- The first write occurs RAMP_DIV cycles after entry.
- When the written value equals target, go to IDLE and drop busy in the same edge. The next command can be accepted on the following cycle.
- ramp_abort high in RAMP: go to IDLE at the next edge with no write on that edge; cur_amp holds its last written value.
- If ramp_abort coincides with a step edge, abort wins and the step is not issued.
- ramp_abort is ignored in IDLE.

Reset mid-ramp:
- Immediate return to reset values; any pending pulse is dropped.

Decomposition:
- Package funct_generator_pkg holds:
  - amp_op_e enum (AMP_CLR=2'b00, AMP_INC, AMP_DEC, AMP_SET).
  - amp_state_e enum (ST_IDLE, ST_RAMP).
  - Shared localparam AMP_RESET_VALUE=8'h10, used by both this block and the amplitude register.
- One sub-module is natural: funct_generator_amp_clamp. It is combinational and computes the next value and saturation flag from the current value, the operation/target and the step.

Test Plan:
- Reset, then INC, INC -> amp_enh pulses with amp_d=8'h11 then 8'h12; cur_amp=8'h12; sat=0.
- CLR after cur_amp=8'h12 -> one-cycle amp_clrh, amp_enh=0, cur_amp=8'h10.
- SET with AMP_MAX=8'hF0, STEP=1, cur_amp=8'hEF, then INC, INC -> SET ramps and ends at 8'hF0 with sat=0; first INC gives amp_d=8'hF0 with sat=1; second INC gives amp_d=8'hF0 with sat=1. DEC from AMP_MIN=0 -> amp_d=8'h00 with sat=1.
- SET 8'h14 from 8'h10, STEP=1, RAMP_DIV=4 -> busy=1, cmd_ready=0; amp_enh every 4 cycles with 11, 12, 13, 14; busy falls on the last write edge. Total 16 cycles from accept to IDLE.
- SET 8'h20 from 8'h10, STEP=3, RAMP_DIV=2 -> amp_d sequence 13, 16, 19, 1C, 1F, 20; the final step is 1, so there is no overshoot.
- SET 8'h40 then ramp_abort after the second step (STEP=1) -> no further amp_enh, cur_amp=8'h12, cmd_ready=1 the next cycle. A separate run asserts rst mid-ramp -> outputs return to reset values asynchronously.
